// File: rtl/mul16_rr_arbiter.sv
// Round-robin arbiter sharing one Q2.13 multiplier between N_REQ requesters.
// Keeps an in-order tag FIFO so each returned product is routed back to its issuer.
//
// state    | meaning
// ST_RUN   | grants enabled
// ST_DRAIN | grants off, waiting for outstanding products to return
// ST_HALT  | nothing outstanding, grants off, O_IDLE high
module mul16_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                  I_CLK,
  input  logic                  I_RST,
  input  logic [N_REQ-1:0]      I_REQ_VLD,
  input  logic [N_REQ*16-1:0]   I_REQ_M1,
  input  logic [N_REQ*16-1:0]   I_REQ_M2,
  output logic [N_REQ-1:0]      O_REQ_RDY,
  output logic                  O_MUL_VLD,
  output logic [15:0]           O_MUL_M1,
  output logic [15:0]           O_MUL_M2,
  input  logic                  I_MUL_VLD,
  input  logic [15:0]           I_MUL_PRODUCT,
  output logic [N_REQ-1:0]      O_RSP_VLD,
  output logic [15:0]           O_RSP_PRODUCT,
  input  logic                  I_DRAIN,
  output logic                  O_IDLE,
  output logic                  O_ERR
);

  localparam int TW = $clog2(N_REQ);
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      ptr_q, ptr_d;
  logic [TW-1:0]      tag_q [TAG_DEPTH];
  logic [TW-1:0]      tag_d [TAG_DEPTH];
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mul_vld_q, mul_vld_d;
  logic [15:0]        mul_m1_q, mul_m1_d, mul_m2_q, mul_m2_d;
  logic [N_REQ-1:0]   rsp_vld_q, rsp_vld_d;
  logic [15:0]        rsp_prod_q, rsp_prod_d;
  logic               err_q, err_d;

  logic               grant_en, win_found, push, pop;
  logic [TW-1:0]      win_idx;
  logic [N_REQ-1:0]   gnt;

  // Rotating search starting just above the last winner.
  always_comb begin
    int k;
    k         = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(ptr_q) + i) % N_REQ;
      if (!win_found && I_REQ_VLD[k]) begin
        win_found = 1'b1;
        win_idx   = TW'(k);
      end
    end
    grant_en = !I_RST && (state_q == ST_RUN) && (cnt_q < CW'(TAG_DEPTH));
    gnt      = '0;
    if (grant_en && win_found) gnt[win_idx] = 1'b1;
  end

  assign push = grant_en && win_found;
  assign pop  = I_MUL_VLD && (cnt_q != '0);

  always_comb begin
    ptr_d      = ptr_q;
    tag_d      = tag_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    mul_vld_d  = 1'b0;
    mul_m1_d   = mul_m1_q;
    mul_m2_d   = mul_m2_q;
    rsp_vld_d  = '0;
    rsp_prod_d = rsp_prod_q;
    err_d      = err_q;
    if (push) begin
      ptr_d       = win_idx;
      tag_d[wr_q] = win_idx;
      wr_d        = wr_q + 1'b1;
      mul_vld_d   = 1'b1;
      mul_m1_d    = I_REQ_M1[16*int'(win_idx) +: 16];
      mul_m2_d    = I_REQ_M2[16*int'(win_idx) +: 16];
    end
    if (pop) begin
      rsp_vld_d[tag_q[rd_q]] = 1'b1;
      rsp_prod_d             = I_MUL_PRODUCT;
      rd_d                   = rd_q + 1'b1;
    end else if (I_MUL_VLD) begin
      err_d = 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // HALT waits until the last product has also been presented on O_RSP_*.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (I_DRAIN) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!I_DRAIN)                                state_d = ST_RUN;
        else if ((cnt_q == '0) && (rsp_vld_q == '0)) state_d = ST_HALT;
      end
      ST_HALT:  if (!I_DRAIN) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q    <= ST_RUN;
      ptr_q      <= TW'(N_REQ - 1);
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      mul_vld_q  <= 1'b0;
      mul_m1_q   <= '0;
      mul_m2_q   <= '0;
      rsp_vld_q  <= '0;
      rsp_prod_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tag_q      <= tag_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      mul_vld_q  <= mul_vld_d;
      mul_m1_q   <= mul_m1_d;
      mul_m2_q   <= mul_m2_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_prod_q <= rsp_prod_d;
      err_q      <= err_d;
    end
  end

  assign O_REQ_RDY     = gnt;
  assign O_MUL_VLD     = mul_vld_q;
  assign O_MUL_M1      = mul_m1_q;
  assign O_MUL_M2      = mul_m2_q;
  assign O_RSP_VLD     = rsp_vld_q;
  assign O_RSP_PRODUCT = rsp_prod_q;
  assign O_IDLE        = (state_q == ST_HALT);
  assign O_ERR         = err_q;

endmodule
